matvec_stream_driver: RTL
=========================

# matvec_stream_driver

- Host-side initiator for the 2x3-by-3x1 floating-point matrix-vector wrapper port (`ready` / `data_valid` / `data` / `calc_done` / `result` / `read_done`).
- Accepts one job of 9 IEEE-754 single words on an upstream valid/ready stream and buffers it.
- Drives the wrapper's load sequence, captures the two result words, acknowledges with `read_done`, then returns the results on a downstream valid/ready stream.
- Sits between the render pipeline's transform scheduler and each matrix-vector compute instance.

## Interface
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in S_WAIT. Used only with `MATVEC_DRV_TIMEOUT_EN`.
- `iClk`  in  1  clock; all logic on the rising edge.
- `iRst`  in  1  synchronous, active-high reset.
- `job_valid`  in  1  upstream word valid.
- `job_ready`  out  1  upstream word accepted when `job_valid` and `job_ready` are both high.
- `job_data`  in  32  job word. Order: A00 A01 A02 A10 A11 A12 B0 B1 B2.
- `res_valid`  out  1  result word valid.
- `res_ready`  in  1  downstream accepts the result word.
- `res_data`  out  32  result word. Row 0 first, then row 1.
- `mat_ready`  in  1  wrapper idle (`ready`).
- `mat_data_valid`  out  1  to wrapper `data_valid`.
- `mat_data`  out  32  to wrapper `data`.
- `mat_calc_done`  in  1  wrapper `calc_done`.
- `mat_result`  in  32  wrapper `result`.
- `mat_read_done`  out  1  to wrapper `read_done`.
- `err`  out  1  sticky timeout flag. Tied to 0 without `MATVEC_DRV_TIMEOUT_EN`.

## Operation
- **Storage**
  - 9x32 job buffer and 4-bit `fill_cnt`.
  - 4-bit `send_cnt`.
  - 2x32 result buffer and 1-bit `out_idx`.
- **States:** S_FILL, S_WAKE, S_SEND, S_WAIT, S_CAP1, S_ACK, S_DRAIN. Reset state is S_FILL.
- **S_FILL**
  - `job_ready`=1.
  - Each handshake writes `buf[fill_cnt]` and increments `fill_cnt`.
  - On the handshake with `fill_cnt`==8: go to S_WAKE and clear `fill_cnt`.
- **S_WAKE**
  - All wrapper outputs are 0.
  - When `mat_ready`=1: go to S_SEND with `send_cnt`=0.
- **S_SEND**
  - `mat_data_valid`=1 for exactly 10 consecutive cycles, `send_cnt` 0..9.
  - `mat_data` = `buf[0]` when `send_cnt`=0 (wake beat, which the wrapper discards).
  - `mat_data` = `buf[send_cnt-1]` otherwise.
  - After `send_cnt`==9: go to S_WAIT.
  - No gaps are permitted, because the wrapper advances its load counter only on valid yet changes phase on its count alone.
- **S_WAIT**
  - On `mat_calc_done`=1: `res[0]` <= `mat_result`, go to S_CAP1.
- **S_CAP1**
  - `res[1]` <= `mat_result` unconditionally (the second `calc_done` cycle), go to S_ACK.
- **S_ACK**
  - `mat_read_done`=1 for exactly one cycle. The wrapper is in WAIT_READ_DONE at this point.
  - Go to S_DRAIN with `out_idx`=0.
- **S_DRAIN**
  - `res_valid`=1 and `res_data`=`res[out_idx]`.
  - A handshake with `out_idx`=0 sets `out_idx` to 1.
  - A handshake with `out_idx`=1 goes to S_FILL.
- **Data handling:** no arithmetic is performed; words pass through bit-exact.
- **Job overlap:** the next job is not accepted until both results have drained (`job_ready`=0 outside S_FILL).

## Timing
- **Reset**
  - Applies on any edge where `iRst`=1, regardless of state.
  - Clears state to S_FILL and clears all counters and `err`.
  - Buffers are not cleared.
- **Reset output values:** `job_ready`=1, `res_valid`=0, `res_data`=0, `mat_data_valid`=0, `mat_data`=0, `mat_read_done`=0, `err`=0.
- **Output decoding**
  - All outputs are decoded from registered state and counters.
  - `res_data` and `mat_data` are 0 outside S_DRAIN and S_SEND respectively.
- **Latency**
  - 9th `job` handshake at cycle t: S_WAKE at t+1.
  - If `mat_ready`=1 at t+1: `mat_data_valid` is high t+2..t+11.
- **Wrapper result:** for a wrapper whose `calc_done` rises at cycle c:
  - `res[0]` is captured at c and `res[1]` at c+1.
  - `mat_read_done` is high at c+2.
  - `res_valid` rises at c+3.
- **`job_valid` and `res_ready`:** no combinational path from either to any output in the same state, except the handshake itself.
- **Reset mid-operation** (S_SEND or S_WAIT): the driver returns to S_FILL. The wrapper must be reset together with the driver; the system ties both resets.
- **Backpressure:** `res_ready`=0 holds `res_valid`/`res_data` stable indefinitely.

## Configuration
- **`MATVEC_DRV_TIMEOUT_EN` defined**
  - A 16-bit watchdog counts cycles in S_WAIT and clears on entry.
  - On reaching `TIMEOUT_CYCLES`: `err` <= 1 (sticky until reset), both `res` entries <= 32'h7FC00000 (quiet NaN), go directly to S_DRAIN with no `mat_read_done`.
- **Not defined:** no counter, `err` is constant 0, and S_WAIT waits forever.

## Test plan
- **Reset:** hold `iRst` 3 cycles mid-S_SEND -> next cycle all outputs at their reset values with `job_ready`=1, and `mat_data_valid` stays 0.
- **Nominal job:**
  - Stimulus: A=[1,2,3;4,5,6] (0x3F800000, 0x40000000, 0x40400000, 0x40800000, 0x40A00000, 0x40C00000), B=[1,1,1].
  - Response: `mat_data` sequence 0x3F800000, then the 9 words, on 10 consecutive cycles; `res_data` 0x40C00000 (6.0), then 0x41700000 (15.0); `mat_read_done` one cycle.
- **Wake stall:** `mat_ready`=0 for 20 cycles after the 9th word -> `mat_data_valid` stays 0 and rises the cycle after `mat_ready` goes high.
- **Backpressure:** `res_ready`=0 for 5 cycles with `res_valid`=1 -> `res_data` held at row 0; `job_ready` stays 0 until row 1 is accepted.
- **Upstream gaps:** `job_valid` toggled every other cycle -> all 9 words captured in order; the result matches the nominal job.
- **Timeout** (macro on, `TIMEOUT_CYCLES`=16, `mat_calc_done` never asserted) -> `err`=1 after 16 cycles in S_WAIT; two 0x7FC00000 results; `mat_read_done` never asserted.

Source files
------------

// File: rtl/matvec_stream_driver.sv
// Host-side initiator for the 2x3 * 3x1 matvec wrapper: buffers a 9-word job, loads the wrapper,
// captures two results, acks with read_done and streams the results out. Optional watchdog: MATVEC_DRV_TIMEOUT_EN.
module matvec_stream_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  input  logic        mat_ready,
  output logic        mat_data_valid,
  output logic [31:0] mat_data,
  input  logic        mat_calc_done,
  input  logic [31:0] mat_result,
  output logic        mat_read_done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_FILL,
    S_WAKE,
    S_SEND,
    S_WAIT,
    S_CAP1,
    S_ACK,
    S_DRAIN
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65536");
  end

  state_t      state, state_nxt;
  logic [31:0] job_buf [9];
  logic [31:0] res_buf [2];
  logic [3:0]  fill_cnt;
  logic [3:0]  send_cnt;
  logic [3:0]  send_idx;
  logic        out_idx;
  logic        timeout_hit;

  // Beat 0 is the wake beat the wrapper discards; it repeats word 0.
  assign send_idx = (send_cnt == 4'd0) ? 4'd0 : send_cnt - 4'd1;

`ifdef MATVEC_DRV_TIMEOUT_EN
  logic [15:0] wdog;
  logic        err_q;

  assign timeout_hit = (state == S_WAIT) && !mat_calc_done &&
                       (wdog == 16'(TIMEOUT_CYCLES - 1));
  assign err = err_q;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_WAIT) wdog <= wdog + 16'd1;
      else                 wdog <= '0;
      if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= S_FILL;
      fill_cnt <= '0;
      send_cnt <= '0;
      out_idx  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FILL && job_valid)
        fill_cnt <= (fill_cnt == 4'd8) ? 4'd0 : fill_cnt + 4'd1;
      if (state == S_SEND) send_cnt <= send_cnt + 4'd1;
      else                 send_cnt <= '0;
      if (state == S_ACK || state == S_WAIT) out_idx <= 1'b0;
      else if (state == S_DRAIN && res_ready) out_idx <= 1'b1;
    end
  end

  // Buffers hold data only; they are deliberately left out of reset.
  always_ff @(posedge iClk) begin
    if (state == S_FILL && job_valid) job_buf[fill_cnt] <= job_data;
    if (state == S_WAIT && mat_calc_done) res_buf[0] <= mat_result;
    if (state == S_CAP1) res_buf[1] <= mat_result;
    if (timeout_hit) begin
      res_buf[0] <= QNAN;
      res_buf[1] <= QNAN;
    end
  end

  always_comb begin
    state_nxt      = state;
    job_ready      = 1'b0;
    res_valid      = 1'b0;
    res_data       = '0;
    mat_data_valid = 1'b0;
    mat_data       = '0;
    mat_read_done  = 1'b0;
    case (state)
      S_FILL: begin
        job_ready = 1'b1;
        if (job_valid && fill_cnt == 4'd8) state_nxt = S_WAKE;
      end
      S_WAKE: begin
        if (mat_ready) state_nxt = S_SEND;
      end
      S_SEND: begin
        mat_data_valid = 1'b1;
        mat_data       = job_buf[send_idx];
        if (send_cnt == 4'd9) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mat_calc_done)    state_nxt = S_CAP1;
        else if (timeout_hit) state_nxt = S_DRAIN;
      end
      S_CAP1: state_nxt = S_ACK;
      S_ACK: begin
        mat_read_done = 1'b1;
        state_nxt     = S_DRAIN;
      end
      S_DRAIN: begin
        res_valid = 1'b1;
        res_data  = res_buf[out_idx];
        if (res_ready && out_idx) state_nxt = S_FILL;
      end
      default: state_nxt = S_FILL;
    endcase
  end

endmodule
